// File: rtl/ex_md_pkg.sv
// rtl/ex_md_pkg.sv - shared op codes, state encoding and op decode helpers for the ex-stage mul/div unit
//
// Purpose: one place for the RV M funct3 codes, the unit's state encoding and
// the small decode functions used by ex_md.
// Ports: none (package).

package ex_md_pkg;

  // RV32M/RV64M funct3 codes
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/ex_md_neg.sv
// rtl/ex_md_neg.sv - conditional two's-complement negator
//
// Purpose: dout = neg ? -din : din. Used for operand absolutes and for the
// sign correction of products, quotients and remainders.
// Ports:
//   neg   in  1  negate when high
//   din   in  W  value
//   dout  out W  conditionally negated value

module md_neg #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/ex_md.sv
// rtl/ex_md.sv - iterative RV M-extension multiply/divide unit for the ex stage
//
// Purpose: accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request over a
// valid/ready handshake, computes it in XLEN+1 cycles (divide-by-zero and
// signed overflow finish on the accept edge) and returns result plus tag.
// Ports:
//   clk, rst              clock (rising), asynchronous active-high reset
//   flush                 synchronous kill of any in-flight op
//   in_valid/in_ready     request handshake; in_ready == (state == IDLE)
//   op, a, b, tag         funct3, rs1, rs2, destination tag
//   out_valid/out_ready   result handshake
//   result, out_tag       result and its tag, stable while in DONE
//   busy                  high in any state but IDLE

module ex_md
  import ex_md_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int              CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN   = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e          state_q, state_d;
  logic [2:0]         op_q;
  logic [TAG_W-1:0]   tag_q;
  logic               sa_q, sb_q;
  // multiplicand for multiplies, divisor for divides
  logic [XLEN-1:0]    opnd_q;
  // multiply: {partial high, remaining multiplier bits}
  // divide:   {partial remainder, dividend bits shifting into quotient}
  logic [2*XLEN-1:0]  acc_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept;
  logic               a_neg, b_neg;
  logic [XLEN-1:0]    abs_a, abs_b;
  logic               div_zero, div_ovf, fast;
  logic [XLEN-1:0]    fast_res;

  logic [XLEN:0]      mul_sum, div_trial;
  logic [2*XLEN-1:0]  acc_step;

  logic [2*XLEN-1:0]  fix_in, fix_out;
  logic [XLEN-1:0]    rem_out;
  logic [XLEN-1:0]    fix_res;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = in_valid & in_ready;

  // ---------------------------------------------------------------- accept
  assign a_neg = op_a_signed(op) & a[XLEN-1];
  assign b_neg = op_b_signed(op) & b[XLEN-1];

  md_neg #(.W(XLEN)) u_abs_a (.neg(a_neg), .din(a), .dout(abs_a));
  md_neg #(.W(XLEN)) u_abs_b (.neg(b_neg), .din(b), .dout(abs_b));

  // op[0]==0 selects the signed divide flavours, op[1] selects remainder
  assign div_zero = op[2] & (b == '0);
  assign div_ovf  = op[2] & ~op[0] & (a == MIN) & (b == '1);
  assign fast     = div_zero | div_ovf;

  always_comb begin
    fast_res = '0;
    if (div_zero) fast_res = op[1] ? a : '1;
    else          fast_res = op[1] ? '0 : MIN;
  end

  // ------------------------------------------------------------- iteration
  // shift-add: add multiplicand into the high half when the low multiplier
  // bit is set, then shift the whole accumulator right by one
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // restoring divide: trial-subtract the divisor from the shifted remainder
  assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};

  always_comb begin
    acc_step = acc_q;
    if (!op_q[2])
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    else if (!div_trial[XLEN])
      acc_step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      acc_step = {acc_q[2*XLEN-2:0], 1'b0};
  end

  // --------------------------------------------------------- sign correction
  // the product or zero-extended quotient takes sa^sb; the remainder takes sa
  assign fix_in = op_q[2] ? {{XLEN{1'b0}}, acc_q[XLEN-1:0]} : acc_q;

  md_neg #(.W(2*XLEN)) u_fix     (.neg(sa_q ^ sb_q), .din(fix_in),                   .dout(fix_out));
  md_neg #(.W(XLEN))   u_fix_rem (.neg(sa_q),        .din(acc_q[2*XLEN-1:XLEN]),     .dout(rem_out));

  always_comb begin
    fix_res = '0;
    if (op_q[2])
      fix_res = op_q[1] ? rem_out : fix_out[XLEN-1:0];
    else
      fix_res = (op_q == MD_MUL) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];
  end

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = fast ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // --------------------------------------------------------------- datapath
  // result/out_tag are written only on the edges that enter DONE; a flush
  // suppresses every update, including an accept in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      tag_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      result  <= '0;
      out_tag <= '0;
    end else if (!flush) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= op;
            tag_q <= tag;
            sa_q  <= a_neg;
            sb_q  <= b_neg;
            if (fast) begin
              result  <= fast_res;
              out_tag <= tag;
            end else begin
              cnt_q  <= CNT_W'(XLEN-1);
              opnd_q <= op[2] ? abs_b : abs_a;
              acc_q  <= {{XLEN{1'b0}}, (op[2] ? abs_a : abs_b)};
            end
          end
        end
        ST_CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - 1'b1;
        end
        ST_FIX: begin
          result  <= fix_res;
          out_tag <= tag_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_md.sv
// tb/tb_ex_md.sv - self-checking bench for ex_md

module tb_ex_md;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int total;
  int bad;
  logic [31:0] last_res;

  ex_md #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // architectural meaning of each M op, computed with 64-bit arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    case (o)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == MIN32 && y == 32'hFFFF_FFFF) return MIN32;
        p = sx / sy; return p[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = ux / uy; return p[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == MIN32 && y == 32'hFFFF_FFFF) return 32'h0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = ux % uy; return p[31:0];
      end
    endcase
  endfunction

  // edges after the accept edge until out_valid: 0 for the early-out cases
  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && (y == 0 || (!o[0] && x == MIN32 && y == 32'hFFFF_FFFF))) return 0;
    return XLEN + 1;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] t, input int hold, input string nm);
    logic [31:0] exp;
    int exp_lat;
    int n;
    exp = ref_md(o, av, bv);
    exp_lat = ref_lat(o, av, bv);
    out_ready = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s in_ready before accept: got %b want 1", nm, in_ready);
    end
    op = o; a = av; b = bv; tag = t; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != exp_lat) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", nm, n, exp_lat);
    end
    total++;
    if (result !== exp) begin
      bad++; $display("FAIL %s result: got %h want %h (op=%0d a=%h b=%h)", nm, result, exp, o, av, bv);
    end
    total++;
    if (out_tag !== t) begin
      bad++; $display("FAIL %s out_tag: got %0d want %0d", nm, out_tag, t);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp || out_tag !== t) begin
        bad++;
        $display("FAIL %s hold cycle %0d: valid=%b in_ready=%b result=%h tag=%0d want 1 0 %h %0d",
                 nm, i, out_valid, in_ready, result, out_tag, exp, t);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL %s after handshake: valid=%b in_ready=%b want 0 1", nm, out_valid, in_ready);
    end
    last_res = exp;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0; tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0 || out_tag !== '0) begin
      bad++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b result=%h out_tag=%0d want 1 0 0 0 0",
               in_ready, out_valid, busy, result, out_tag);
    end
    last_res = '0;
  endtask

  task automatic test_mul();
    run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  0, "mul");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  0, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  0, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  0, "mulhsu");
  endtask

  task automatic test_div();
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, "rem");
    run_op(3'd5, 32'd100,       32'd7, 5'd8, 0, "divu");
    run_op(3'd7, 32'd100,       32'd7, 5'd9, 0, "remu");
  endtask

  task automatic test_fast_path();
    run_op(3'd4, 32'h1234,      32'd0,         5'd10, 0, "div_by_zero");
    run_op(3'd6, 32'h1234,      32'd0,         5'd11, 0, "rem_by_zero");
    run_op(3'd5, 32'hDEAD_BEEF, 32'd0,         5'd12, 0, "divu_by_zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0, "rem_ovf");
  endtask

  task automatic test_hold();
    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, 5, "hold_mulh");
    run_op(3'd7, 32'd55,        32'd0,         5'd22, 5, "hold_fast");
  endtask

  task automatic test_flush();
    // flush during the 10th CALC cycle
    @(negedge clk);
    op = 3'd0; a = 32'd3; b = 32'd4; tag = 5'd30; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== last_res) begin
      bad++;
      $display("FAIL flush_calc: in_ready=%b out_valid=%b busy=%b result=%h want 1 0 0 %h",
               in_ready, out_valid, busy, result, last_res);
    end
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (out_valid === 1'b1) seen++;
      end
      total++;
      if (seen != 0) begin
        bad++; $display("FAIL flush_no_valid: out_valid seen %0d cycles want 0", seen);
      end
    end
    // flush coinciding with an accept drops the request
    op = 3'd4; a = 32'd9; b = 32'd0; tag = 5'd31; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== last_res) begin
      bad++;
      $display("FAIL flush_accept: in_ready=%b out_valid=%b busy=%b result=%h want 1 0 0 %h",
               in_ready, out_valid, busy, result, last_res);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    op = 3'd5; a = 32'd1000; b = 32'd3; tag = 5'd4; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || out_tag !== '0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b in_ready=%b out_valid=%b result=%h out_tag=%0d want 0 1 0 0 0",
               busy, in_ready, out_valid, result, out_tag);
    end
    #1 rst = 1'b0;
    last_res = '0;
  endtask

  task automatic test_back_to_back();
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 0, "b2b_0");
    run_op(3'd4, 32'h8000_0000, 32'd1,         5'd16, 0, "b2b_1");
    run_op(3'd6, 32'h8000_0001, 32'hFFFF_FFFF, 5'd17, 0, "b2b_2");
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] av, bv;
    int sel;
    for (int i = 0; i < 40; i++) begin
      o  = 3'($urandom_range(0, 7));
      av = $urandom;
      bv = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) bv = 32'd0;
      else if (sel == 1) begin av = MIN32; bv = 32'hFFFF_FFFF; end
      else if (sel == 2) bv = 32'($urandom_range(1, 15));
      else if (sel == 3) av = 32'($urandom_range(0, 15));
      run_op(o, av, bv, 5'($urandom_range(0, 31)), 0, "random");
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_hold();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
